action_dispatch: RTL and testbench

Downstream stage of the action-selection block. It consumes the 16-bit destination mask (action), the aggregation flag and the done strobe that selection produces. For each destination bit set in the mask, it streams a fixed-length packet from packet memory to the radio/TX interface using a valid/ready handshake. If the aggregation flag is set, it copies the packet into a circular aggregation buffer in memory instead of transmitting it.

---
 rtl/action_dispatch_pkg.sv | 23 ++
 rtl/action_dispatch_prio_enc16.sv | 18 +
 rtl/action_dispatch.sv | 185 ++++++++++++++++++
 tb/tb_action_dispatch.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/action_dispatch_pkg.sv
// Shared definitions for the action-selection and dispatch stages:
// bus widths, packet/aggregation buffer layout defaults and the dispatch FSM encoding.
package action_dispatch_pkg;

    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_PKT_WORDS = 4;
    localparam int DEF_AGG_SLOTS = 4;

    localparam logic [DEF_ADDR_W-1:0] DEF_PKT_BASE = 11'h010;
    localparam logic [DEF_ADDR_W-1:0] DEF_AGG_BASE = 11'h100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_RD,
        ST_XFER,
        ST_AGGW,
        ST_FIN
    } state_t;

endpackage

// File: rtl/action_dispatch_prio_enc16.sv
// Lowest-set-bit priority encoder over a 16-bit destination mask.
module prio_enc16 (
    input  logic [15:0] req,
    output logic [3:0]  idx,
    output logic        valid
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/action_dispatch.sv
// Streams one fixed-length packet per destination bit to the TX interface, or copies
// a single packet into the circular aggregation buffer when the aggregation flag is set.
module action_dispatch
    import action_dispatch_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                PKT_WORDS = DEF_PKT_WORDS,
    parameter logic [ADDR_W-1:0] PKT_BASE  = DEF_PKT_BASE,
    parameter logic [ADDR_W-1:0] AGG_BASE  = DEF_AGG_BASE,
    parameter int                AGG_SLOTS = DEF_AGG_SLOTS
) (
    input  logic              clock,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic [15:0]       action,
    input  logic              for_aggregation,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [3:0]        tx_dest,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic              agg_wr_en,
    output logic [ADDR_W-1:0] agg_addr,
    output logic [DATA_W-1:0] agg_data,
    input  logic              agg_clr,
    output logic [2:0]        agg_count,
    output logic              agg_drop,
    output logic              busy,
    output logic              done
);

    localparam int WI_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int PTR_W = (AGG_SLOTS > 1) ? $clog2(AGG_SLOTS) : 1;

    localparam logic [WI_W-1:0]  LAST_IDX = WI_W'(PKT_WORDS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(AGG_SLOTS - 1);
    localparam logic [2:0]       FULL_CNT = 3'(AGG_SLOTS);

    state_t            state, next_state;
    logic [15:0]       mask;
    logic              agg;
    logic [3:0]        cur_dest;
    logic [WI_W-1:0]   word_idx;
    logic [PTR_W-1:0]  wr_ptr;
    logic              xfer_first;
    logic [DATA_W-1:0] data_hold;

    logic [3:0]        enc_idx;
    logic              enc_valid;
    logic              is_last;
    logic              agg_full;
    logic [15:0]       mask_rest;

    prio_enc16 u_prio_enc16 (
        .req   (mask),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign is_last   = (word_idx == LAST_IDX);
    assign agg_full  = (agg_count == FULL_CNT);
    assign mask_rest = mask & ~(16'(1) << cur_dest);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= next_state;
    end

    // NOTE: every output and next_state gets a default before the case; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        next_state = state;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        tx_dest    = '0;
        tx_last    = 1'b0;
        agg_wr_en  = 1'b0;
        agg_addr   = '0;
        agg_data   = '0;
        agg_drop   = 1'b0;
        done       = 1'b0;

        case (state)
            ST_IDLE: if (start && en) next_state = ST_LOAD;
            ST_LOAD: begin
                if (agg && agg_full) begin
                    agg_drop   = 1'b1;
                    next_state = ST_FIN;
                end else if (agg)       next_state = ST_RD;
                else if (mask == '0)    next_state = ST_FIN;
                else                    next_state = ST_SCAN;
            end
            ST_SCAN: next_state = enc_valid ? ST_RD : ST_FIN;
            ST_RD: begin
                mem_rd_en  = 1'b1;
                mem_addr   = PKT_BASE + ADDR_W'(word_idx);
                next_state = agg ? ST_AGGW : ST_XFER;
            end
            ST_XFER: begin
                // Read data is live only in the first XFER cycle; a stall replays the held copy.
                tx_valid = 1'b1;
                tx_data  = xfer_first ? mem_rdata : data_hold;
                tx_dest  = cur_dest;
                tx_last  = is_last;
                if (tx_ready) begin
                    if (!is_last)              next_state = ST_RD;
                    else if (mask_rest != '0)  next_state = ST_SCAN;
                    else                       next_state = ST_FIN;
                end
            end
            ST_AGGW: begin
                agg_wr_en  = 1'b1;
                agg_addr   = AGG_BASE + ADDR_W'(wr_ptr) * ADDR_W'(PKT_WORDS) + ADDR_W'(word_idx);
                agg_data   = mem_rdata;
                next_state = is_last ? ST_FIN : ST_RD;
            end
            ST_FIN: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The mask and flag travel with the start strobe, so they are captured on acceptance.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            mask       <= '0;
            agg        <= 1'b0;
            cur_dest   <= '0;
            word_idx   <= '0;
            xfer_first <= 1'b0;
            data_hold  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && en) begin
                        mask     <= action;
                        agg      <= for_aggregation;
                        word_idx <= '0;
                    end
                end
                ST_SCAN: cur_dest <= enc_idx;
                ST_RD:   xfer_first <= 1'b1;
                ST_XFER: begin
                    xfer_first <= 1'b0;
                    if (xfer_first) data_hold <= mem_rdata;
                    if (tx_ready) begin
                        if (is_last) begin
                            mask[cur_dest] <= 1'b0;
                            word_idx       <= '0;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                ST_AGGW: word_idx <= is_last ? '0 : word_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // A clear from the consumer outranks a slot commit in the same cycle.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            wr_ptr    <= '0;
            agg_count <= '0;
        end else if (agg_clr) begin
            wr_ptr    <= '0;
            agg_count <= '0;
        end else if (state == ST_AGGW && is_last) begin
            wr_ptr    <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            agg_count <= agg_count + 3'd1;
        end
    end

endmodule

// File: tb/tb_action_dispatch.sv
// Randomized bench for action_dispatch against a packet-level model of TX and aggregation traffic.
module tb_action_dispatch;
    import action_dispatch_pkg::*;

    localparam int ADDR_W    = DEF_ADDR_W;
    localparam int DATA_W    = DEF_DATA_W;
    localparam int PW        = DEF_PKT_WORDS;
    localparam int AGG_SLOTS = DEF_AGG_SLOTS;
    localparam int PKT_BASE  = int'(DEF_PKT_BASE);
    localparam int AGG_BASE  = int'(DEF_AGG_BASE);

    typedef struct packed {
        logic [3:0]        dest;
        logic [DATA_W-1:0] data;
        logic              last;
    } tx_word_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } agg_word_t;

    logic              clock = 1'b0;
    logic              nrst = 1'b0;
    logic              en = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       action = '0;
    logic              for_aggregation = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic [3:0]        tx_dest;
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              agg_wr_en;
    logic [ADDR_W-1:0] agg_addr;
    logic [DATA_W-1:0] agg_data;
    logic              agg_clr = 1'b0;
    logic [2:0]        agg_count;
    logic              agg_drop;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt, drop_cnt, rd_cnt, txv_cnt;
    int first_valid_cyc, done_cyc, last_hs_cyc, start_cyc;
    int model_count, model_ptr;
    tx_word_t  obs_tx[$];
    tx_word_t  exp_tx[$];
    agg_word_t obs_agg[$];
    bit        stalled = 1'b0;
    tx_word_t  held_tx;

    action_dispatch dut (
        .clock           (clock),
        .nrst            (nrst),
        .en              (en),
        .start           (start),
        .action          (action),
        .for_aggregation (for_aggregation),
        .mem_addr        (mem_addr),
        .mem_rd_en       (mem_rd_en),
        .mem_rdata       (mem_rdata),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_dest         (tx_dest),
        .tx_data         (tx_data),
        .tx_last         (tx_last),
        .agg_wr_en       (agg_wr_en),
        .agg_addr        (agg_addr),
        .agg_data        (agg_data),
        .agg_clr         (agg_clr),
        .agg_count       (agg_count),
        .agg_drop        (agg_drop),
        .busy            (busy),
        .done            (done)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always @(posedge clock) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Mid-cycle observer: records traffic and checks that a stalled word stays put.
    always @(negedge clock) begin
        if (nrst) begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (agg_drop) drop_cnt++;
            if (mem_rd_en) rd_cnt++;
            if (tx_valid) begin
                txv_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (stalled && tx_valid) begin
                checks++;
                if (tx_word_t'{tx_dest, tx_data, tx_last} !== held_tx) begin
                    errors++;
                    $display("FAIL stall_hold: dest %0d data %h last %b changed, held dest %0d data %h last %b",
                             tx_dest, tx_data, tx_last, held_tx.dest, held_tx.data, held_tx.last);
                end
            end
            if (tx_valid && tx_ready) begin
                obs_tx.push_back(tx_word_t'{tx_dest, tx_data, tx_last});
                last_hs_cyc = cyc;
            end
            if (agg_wr_en) obs_agg.push_back(agg_word_t'{agg_addr, agg_data});
            stalled = tx_valid && !tx_ready;
            held_tx = tx_word_t'{tx_dest, tx_data, tx_last};
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic void model_tx(input logic [15:0] a);
        exp_tx.delete();
        for (int d = 0; d < 16; d++)
            if (a[d])
                for (int k = 0; k < PW; k++)
                    exp_tx.push_back(tx_word_t'{4'(d), mem[PKT_BASE + k], (k == PW - 1)});
    endfunction

    task automatic load_packet(input bit fixed);
        for (int k = 0; k < PW; k++)
            mem[PKT_BASE + k] = fixed ? DATA_W'(16'hA0 + k) : DATA_W'($urandom);
    endtask

    task automatic clear_obs();
        obs_tx.delete();
        obs_agg.delete();
        done_cnt = 0; drop_cnt = 0; rd_cnt = 0; txv_cnt = 0;
        first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
    endtask

    task automatic pulse_start(input logic [15:0] a, input logic agg_f, input logic e);
        @(posedge clock); #1;
        action = a; for_aggregation = agg_f; en = e; start = 1'b1; start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0; en = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge clock); #1 agg_clr = 1'b1;
        @(posedge clock); #1 agg_clr = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready, input string name);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock);
            if (done_cnt > d0) begin seen = 1'b1; break; end
            #1;
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done not seen, required within 1000 cycles", name);
        end
        #1 tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({tx_valid, busy, done, mem_rd_en, agg_wr_en, agg_drop, agg_count} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid %b busy %b done %b rd %b wr %b drop %b count %0d, required all 0",
                     tx_valid, busy, done, mem_rd_en, agg_wr_en, agg_drop, agg_count);
        end
        checks++;
        if ({tx_data, tx_dest, tx_last, mem_addr, agg_addr, agg_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: tx_data %h dest %0d mem_addr %h agg_addr %h agg_data %h, required 0",
                     tx_data, tx_dest, mem_addr, agg_addr, agg_data);
        end
        @(posedge clock); #1 nrst = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy %b, required 0", busy);
        end
    endtask

    task automatic test_tx_basic();
        load_packet(1'b1);
        clear_obs();
        tx_ready = 1'b1;
        model_tx(16'h0041);
        pulse_start(16'h0041, 1'b0, 1'b1);
        wait_done(1'b0, "basic");
        checks++;
        if (obs_tx.size() !== exp_tx.size()) begin
            errors++;
            $display("FAIL basic_len: %0d words, required %0d", obs_tx.size(), exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            checks++;
            if (obs_tx[i] !== exp_tx[i]) begin
                errors++;
                $display("FAIL basic_word%0d: dest %0d data %h last %b, required dest %0d data %h last %b", i,
                         obs_tx[i].dest, obs_tx[i].data, obs_tx[i].last, exp_tx[i].dest, exp_tx[i].data, exp_tx[i].last);
            end
        end
        checks++;
        if (first_valid_cyc !== start_cyc + 4) begin
            errors++;
            $display("FAIL basic_first_valid: cycle %0d, required %0d", first_valid_cyc, start_cyc + 4);
        end
        // LOAD, then per packet one SCAN plus RD/XFER per word.
        checks++;
        if (last_hs_cyc !== start_cyc + 1 + 2 * (1 + 2 * PW)) begin
            errors++;
            $display("FAIL basic_throughput: last handshake cycle %0d, required %0d", last_hs_cyc, start_cyc + 1 + 2 * (1 + 2 * PW));
        end
        checks++;
        if (done_cyc !== last_hs_cyc + 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL basic_done: cycle %0d count %0d, required cycle %0d count 1", done_cyc, done_cnt, last_hs_cyc + 1);
        end
        checks++;
        if (rd_cnt !== 2 * PW) begin
            errors++;
            $display("FAIL basic_reads: %0d, required %0d", rd_cnt, 2 * PW);
        end
    endtask

    task automatic test_backpressure();
        bit reached;
        load_packet(1'b0);
        clear_obs();
        tx_ready = 1'b1;
        model_tx(16'h0041);
        pulse_start(16'h0041, 1'b0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            if (obs_tx.size() >= 2) begin reached = 1'b1; break; end
        end
        #1 tx_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1 tx_ready = 1'b1;
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL bp_reach: second word not seen, required within 100 cycles");
        end
        wait_done(1'b0, "bp");
        checks++;
        if (obs_tx.size() !== exp_tx.size()) begin
            errors++;
            $display("FAIL bp_len: %0d words, required %0d", obs_tx.size(), exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            checks++;
            if (obs_tx[i] !== exp_tx[i]) begin
                errors++;
                $display("FAIL bp_word%0d: dest %0d data %h last %b, required dest %0d data %h last %b", i,
                         obs_tx[i].dest, obs_tx[i].data, obs_tx[i].last, exp_tx[i].dest, exp_tx[i].data, exp_tx[i].last);
            end
        end
        checks++;
        if (txv_cnt !== 2 * PW + 3 || done_cnt !== 1) begin
            errors++;
            $display("FAIL bp_valid_cycles: %0d valid cycles done %0d, required %0d and 1", txv_cnt, done_cnt, 2 * PW + 3);
        end
    endtask

    task automatic test_random_tx();
        logic [15:0] a;
        for (int n = 0; n < 4; n++) begin
            a = 16'($urandom);
            load_packet(1'b0);
            clear_obs();
            model_tx(a);
            pulse_start(a, 1'b0, 1'b1);
            wait_done(1'b1, "rand");
            checks++;
            if (obs_tx.size() !== exp_tx.size() || done_cnt !== 1) begin
                errors++;
                $display("FAIL rand%0d_len: action %h %0d words done %0d, required %0d words done 1",
                         n, a, obs_tx.size(), done_cnt, exp_tx.size());
            end
            for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
                checks++;
                if (obs_tx[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: dest %0d data %h last %b, required dest %0d data %h last %b", n, i,
                             obs_tx[i].dest, obs_tx[i].data, obs_tx[i].last, exp_tx[i].dest, exp_tx[i].data, exp_tx[i].last);
                end
            end
        end
    endtask

    task automatic test_empty_ignored();
        clear_obs();
        pulse_start(16'h0000, 1'b0, 1'b1);
        wait_done(1'b0, "empty");
        checks++;
        if (done_cyc !== start_cyc + 2 || rd_cnt !== 0 || txv_cnt !== 0) begin
            errors++;
            $display("FAIL empty: done cycle %0d reads %0d valid %0d, required cycle %0d reads 0 valid 0",
                     done_cyc, rd_cnt, txv_cnt, start_cyc + 2);
        end

        clear_obs();
        pulse_start(16'h0001, 1'b0, 1'b0);
        repeat (6) @(negedge clock);
        checks++;
        if (done_cnt !== 0 || rd_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_low: done %0d reads %0d busy %b, required 0 0 0", done_cnt, rd_cnt, busy);
        end

        load_packet(1'b0);
        clear_obs();
        model_tx(16'h0003);
        pulse_start(16'h0003, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        #1 action = 16'h8000; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done(1'b0, "busy_start");
        repeat (3) @(negedge clock);
        checks++;
        if (obs_tx.size() !== exp_tx.size() || done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: %0d words done %0d busy %b, required %0d words done 1 busy 0",
                     obs_tx.size(), done_cnt, busy, exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            checks++;
            if (obs_tx[i] !== exp_tx[i]) begin
                errors++;
                $display("FAIL busy_start_word%0d: dest %0d data %h, required dest %0d data %h",
                         i, obs_tx[i].dest, obs_tx[i].data, exp_tx[i].dest, exp_tx[i].data);
            end
        end
    endtask

    task automatic test_agg();
        bit full;
        int base;
        pulse_clr();
        model_count = 0;
        model_ptr = 0;
        load_packet(1'b0);
        tx_ready = 1'b1;
        for (int n = 0; n < AGG_SLOTS + 1; n++) begin
            clear_obs();
            full = (model_count == AGG_SLOTS);
            base = AGG_BASE + model_ptr * PW;
            pulse_start(16'hFFFF, 1'b1, 1'b1);
            wait_done(1'b0, "agg");
            checks++;
            if (obs_agg.size() !== (full ? 0 : PW) || drop_cnt !== (full ? 1 : 0)) begin
                errors++;
                $display("FAIL agg%0d_shape: %0d writes %0d drops, required %0d writes %0d drops",
                         n, obs_agg.size(), drop_cnt, full ? 0 : PW, full ? 1 : 0);
            end
            for (int k = 0; k < obs_agg.size() && !full && k < PW; k++) begin
                checks++;
                if (obs_agg[k] !== agg_word_t'{ADDR_W'(base + k), mem[PKT_BASE + k]}) begin
                    errors++;
                    $display("FAIL agg%0d_write%0d: addr %h data %h, required addr %h data %h",
                             n, k, obs_agg[k].addr, obs_agg[k].data, base + k, mem[PKT_BASE + k]);
                end
            end
            if (!full) begin
                model_count++;
                model_ptr = (model_ptr + 1) % AGG_SLOTS;
            end
            checks++;
            if (agg_count !== 3'(model_count) || txv_cnt !== 0 || done_cnt !== 1) begin
                errors++;
                $display("FAIL agg%0d_status: count %0d valid %0d done %0d, required count %0d valid 0 done 1",
                         n, agg_count, txv_cnt, done_cnt, model_count);
            end
        end
    endtask

    task automatic test_agg_clr();
        bit hit;
        logic [ADDR_W-1:0] last_addr;
        pulse_clr();
        load_packet(1'b0);
        clear_obs();
        pulse_start(16'h0000, 1'b1, 1'b1);
        wait_done(1'b0, "clr_pre");
        checks++;
        if (agg_count !== 3'd1) begin
            errors++;
            $display("FAIL clr_pre_count: %0d, required 1", agg_count);
        end
        last_addr = ADDR_W'(AGG_BASE + 1 * PW + PW - 1);
        clear_obs();
        pulse_start(16'h0000, 1'b1, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (agg_wr_en && agg_addr == last_addr) begin
                agg_clr = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        @(posedge clock); #1 agg_clr = 1'b0;
        wait_done(1'b0, "clr");
        checks++;
        if (!hit || agg_count !== 3'd0) begin
            errors++;
            $display("FAIL clr_collide: last write seen %b count %0d, required 1 and 0", hit, agg_count);
        end
        clear_obs();
        pulse_start(16'h0000, 1'b1, 1'b1);
        wait_done(1'b0, "clr_post");
        checks++;
        if (obs_agg.size() == 0 || obs_agg[0].addr !== ADDR_W'(AGG_BASE) || agg_count !== 3'd1) begin
            errors++;
            $display("FAIL clr_post: %0d writes first addr %h count %0d, required first addr %h count 1",
                     obs_agg.size(), obs_agg.size() > 0 ? obs_agg[0].addr : '0, agg_count, AGG_BASE);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_packet(1'b0);
        clear_obs();
        tx_ready = 1'b0;
        pulse_start(16'h0010, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx_valid) begin seen = 1'b1; break; end
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (!seen || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid seen %b, after reset valid %b busy %b done %b, required 1 0 0 0",
                     seen, tx_valid, busy, done);
        end
        @(posedge clock); #1 nrst = 1'b1; tx_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || agg_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy %b count %0d, required 0 0", busy, agg_count);
        end
        load_packet(1'b0);
        clear_obs();
        model_tx(16'h0201);
        pulse_start(16'h0201, 1'b0, 1'b1);
        wait_done(1'b0, "post_reset");
        checks++;
        if (obs_tx.size() !== exp_tx.size() || first_valid_cyc !== start_cyc + 4) begin
            errors++;
            $display("FAIL post_reset_len: %0d words first valid %0d, required %0d words first valid %0d",
                     obs_tx.size(), first_valid_cyc, exp_tx.size(), start_cyc + 4);
        end
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            checks++;
            if (obs_tx[i] !== exp_tx[i]) begin
                errors++;
                $display("FAIL post_reset_word%0d: dest %0d data %h last %b, required dest %0d data %h last %b", i,
                         obs_tx[i].dest, obs_tx[i].data, obs_tx[i].last, exp_tx[i].dest, exp_tx[i].data, exp_tx[i].last);
            end
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_tx_basic();
        test_backpressure();
        test_random_tx();
        test_empty_ignored();
        test_agg();
        test_agg_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
